// File: rtl/aes_inv_mix_seq.sv
// rtl/aes_inv_mix_seq.sv - sequential AES inverse round tail: AddRoundKey then InvMixColumns, one column per cycle
//
// Ports:
//   Clk        rising-edge clock
//   Reset_n    asynchronous active-low reset
//   Start      request to process one state, sampled only in IDLE
//   Bypass_mix last-round flag (AddRoundKey only), sampled with Start
//   State_in   128-bit state, word0 = [127:96] ... word3 = [31:0]
//   Round_key  128-bit round key, same word order, sampled with Start
//   State_out  128-bit result register, held until the next result
//   Busy       high whenever the FSM is not in IDLE
//   Done       one-cycle pulse, State_out valid from this cycle

module aes_inv_mix_seq (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Bypass_mix,
    input  logic [127:0] State_in,
    input  logic [127:0] Round_key,
    output logic [127:0] State_out,
    output logic         Busy,
    output logic         Done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARK  = 3'd1,
        S_COL  = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [127:0]      lat_state_q, lat_state_d;
    logic [127:0]      lat_key_q, lat_key_d;
    logic              bypass_q, bypass_d;
    // Index 3 is word0 ([127:96]) so a flat 128-bit assignment keeps word order.
    logic [3:0][31:0]  work_q, work_d;
    logic [127:0]      out_q, out_d;

    logic [1:0]        col_idx;
    logic [31:0]       col_word;
    logic [31:0]       col_mixed;

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xt(xt(xt(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        logic [7:0] x2, x8;
        x2 = xt(b);
        x8 = xt(xt(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        logic [7:0] x4, x8;
        x4 = xt(xt(b));
        x8 = xt(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Byte a0 is the word MSB.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] o0, o1, o2, o3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        o0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
        o1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
        o2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
        o3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
        return {o0, o1, o2, o3};
    endfunction

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_ARK;
            S_ARK:   state_d = bypass_q ? S_FIN : S_COL;
            S_COL:   if (cnt_q == 2'd3) state_d = S_FIN;
            S_FIN:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        Busy = (state_q != S_IDLE);
        Done = (state_q == S_DONE);
    end

    assign State_out = out_q;

    // Counter value 0 selects word0, which lives at packed index 3.
    assign col_idx   = 2'd3 - cnt_q;
    assign col_word  = work_q[col_idx];
    assign col_mixed = inv_mix_col(col_word);

    // Datapath next-state.
    always_comb begin
        cnt_d       = cnt_q;
        lat_state_d = lat_state_q;
        lat_key_d   = lat_key_q;
        bypass_d    = bypass_q;
        work_d      = work_q;
        out_d       = out_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    lat_state_d = State_in;
                    lat_key_d   = Round_key;
                    bypass_d    = Bypass_mix;
                end
            end
            S_ARK: begin
                work_d = lat_state_q ^ lat_key_q;
                cnt_d  = 2'd0;
            end
            S_COL: begin
                work_d[col_idx] = col_mixed;
                // Saturate at 3; ARK reloads 0 for the next operation.
                if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
            end
            S_FIN: begin
                out_d = work_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q       <= 2'd0;
            lat_state_q <= 128'h0;
            lat_key_q   <= 128'h0;
            bypass_q    <= 1'b0;
            work_q      <= '0;
            out_q       <= 128'h0;
        end else begin
            cnt_q       <= cnt_d;
            lat_state_q <= lat_state_d;
            lat_key_q   <= lat_key_d;
            bypass_q    <= bypass_d;
            work_q      <= work_d;
            out_q       <= out_d;
        end
    end

endmodule
